// File: rtl/control_sequencer.sv
// Buffered instruction sequencer: host words are queued in a FIFO, then issued
// onto registered control outputs for a programmable repeat count, with an optional done barrier.
module control_sequencer #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 2,
  parameter int ADDR_W = 2,
  parameter int PTR_W  = 3,
  parameter int PATH_W = 4,
  parameter int REP_W  = 8,
  parameter int DEPTH  = 8,
  localparam int INSTR_W = 5 + COL_W + ROW_W + ADDR_W + PTR_W + 4*DATA_W + PATH_W + REP_W + 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid_in,
  output logic               instr_ready_out,
  input  logic               pause_in,
  input  logic               done_in,
  output logic               sys_switch_in,
  output logic               ub_rd_start_in,
  output logic               ub_rd_transpose,
  output logic               ub_wr_host_valid_in_1,
  output logic               ub_wr_host_valid_in_2,
  output logic [COL_W-1:0]   ub_rd_col_size,
  output logic [ROW_W-1:0]   ub_rd_row_size,
  output logic [ADDR_W-1:0]  ub_rd_addr_in,
  output logic [PTR_W-1:0]   ub_ptr_sel,
  output logic [DATA_W-1:0]  ub_wr_host_data_in_1,
  output logic [DATA_W-1:0]  ub_wr_host_data_in_2,
  output logic [PATH_W-1:0]  vpu_data_pathway,
  output logic [DATA_W-1:0]  inv_batch_size_times_two_in,
  output logic [DATA_W-1:0]  vpu_leak_factor_in,
  output logic               instr_done_out,
  output logic               busy_out,
  output logic [CNT_W-1:0]   fifo_count_out
);

  localparam int AW = $clog2(DEPTH);

  // Packed structs are declared MSB-first, so the field list reads bottom-up.
  typedef struct packed {
    logic [DATA_W-1:0] leak;
    logic [DATA_W-1:0] inv_batch;
    logic [PATH_W-1:0] pathway;
    logic [DATA_W-1:0] data_2;
    logic [DATA_W-1:0] data_1;
    logic [PTR_W-1:0]  ptr;
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              wr_valid_2;
    logic              wr_valid_1;
    logic              transpose;
    logic              rd_start;
    logic              sys_switch;
  } ctrl_t;

  typedef struct packed {
    logic             wait_en;
    logic [REP_W-1:0] rep;
    ctrl_t            ctrl;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  instr_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, fifo_empty;
  instr_t           head;

  state_e           state_q;
  ctrl_t            cur_q, hold_ctrl, out_q;
  logic             cur_wait_q;
  logic [REP_W-1:0] rem_q;
  logic             done_q;

  assign instr_ready_out = (count_q < CNT_W'(DEPTH));
  assign fifo_empty      = (count_q == '0);
  assign push            = instr_valid_in && instr_ready_out;
  assign head            = mem_q[rd_ptr_q];

  // A pop is exactly a load of the next instruction into the issue registers.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    pop       = 1'b0;
    hold_ctrl = cur_q;
    hold_ctrl.rd_start = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = !fifo_empty && !pause_in;
      S_ISSUE: pop = (rem_q == '0) && !cur_wait_q && !fifo_empty && !pause_in;
      S_WAIT:  pop = done_in && !fifo_empty;
      default: pop = 1'b0;
    endcase
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr_t'(instr_in);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // rem_q counts issue cycles still to be shown after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      cur_q      <= '0;
      cur_wait_q <= 1'b0;
      rem_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      out_q  <= '0;
      done_q <= 1'b0;
      if (pop) begin
        state_q    <= S_ISSUE;
        out_q      <= head.ctrl;
        cur_q      <= head.ctrl;
        cur_wait_q <= head.wait_en;
        rem_q      <= head.rep;
        done_q     <= (head.rep == '0);
      end else begin
        unique case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_ISSUE: begin
            if (rem_q == '0) begin
              state_q <= cur_wait_q ? S_WAIT : S_IDLE;
            end else if (!pause_in) begin
              out_q  <= hold_ctrl;
              rem_q  <= rem_q - REP_W'(1);
              done_q <= (rem_q == REP_W'(1));
            end
          end
          S_WAIT: if (done_in) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sys_switch_in               = out_q.sys_switch;
  assign ub_rd_start_in              = out_q.rd_start;
  assign ub_rd_transpose             = out_q.transpose;
  assign ub_wr_host_valid_in_1       = out_q.wr_valid_1;
  assign ub_wr_host_valid_in_2       = out_q.wr_valid_2;
  assign ub_rd_col_size              = out_q.col;
  assign ub_rd_row_size              = out_q.row;
  assign ub_rd_addr_in               = out_q.addr;
  assign ub_ptr_sel                  = out_q.ptr;
  assign ub_wr_host_data_in_1        = out_q.data_1;
  assign ub_wr_host_data_in_2        = out_q.data_2;
  assign vpu_data_pathway            = out_q.pathway;
  assign inv_batch_size_times_two_in = out_q.inv_batch;
  assign vpu_leak_factor_in          = out_q.leak;
  assign instr_done_out              = done_q;
  assign busy_out                    = !fifo_empty || (state_q != S_IDLE);
  assign fifo_count_out              = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst, valid, pause, done;
  logic [96:0] instr;

  logic        ready, sys_sw, rd_start, transpose, wv1, wv2, instr_done, busy;
  logic [1:0]  col;
  logic [7:0]  row;
  logic [1:0]  addr;
  logic [2:0]  ptr;
  logic [15:0] d1, d2, inv_b, leak;
  logic [3:0]  path;
  logic [3:0]  count;

  int checks = 0;
  int fails  = 0;

  // Reference model state: pending queue, current instruction, issue progress.
  logic [96:0] mq[$];
  logic [96:0] m_cur;
  int          m_mode = 0;   // 0 idle, 1 issuing, 2 waiting for done
  int          m_shown = 0;  // issue cycles shown so far for m_cur
  bit          m_act = 0;    // current cycle shows m_cur
  bit          m_first = 0;  // current cycle is the first issue cycle

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk                         (clk),
    .rst                         (rst),
    .instr_in                    (instr),
    .instr_valid_in              (valid),
    .instr_ready_out             (ready),
    .pause_in                    (pause),
    .done_in                     (done),
    .sys_switch_in               (sys_sw),
    .ub_rd_start_in              (rd_start),
    .ub_rd_transpose             (transpose),
    .ub_wr_host_valid_in_1       (wv1),
    .ub_wr_host_valid_in_2       (wv2),
    .ub_rd_col_size              (col),
    .ub_rd_row_size              (row),
    .ub_rd_addr_in               (addr),
    .ub_ptr_sel                  (ptr),
    .ub_wr_host_data_in_1        (d1),
    .ub_wr_host_data_in_2        (d2),
    .vpu_data_pathway            (path),
    .inv_batch_size_times_two_in (inv_b),
    .vpu_leak_factor_in          (leak),
    .instr_done_out              (instr_done),
    .busy_out                    (busy),
    .fifo_count_out              (count)
  );

  function automatic logic [96:0] rand_instr(int rep_max, bit can_wait);
    logic [96:0] w;
    w = 97'({$urandom(), $urandom(), $urandom(), $urandom()});
    w[95:88] = 8'($urandom_range(0, rep_max));
    w[96]    = can_wait && ($urandom_range(0, 5) == 0);
    return w;
  endfunction

  function automatic logic [94:0] obs();
    return {instr_done, busy, ready, count,
            leak, inv_b, path, d2, d1, ptr, addr, row, col, wv2, wv1, transpose, rd_start, sys_sw};
  endfunction

  function automatic logic [94:0] exp_v();
    logic [87:0] c;
    logic        dn;
    c  = '0;
    dn = 1'b0;
    if (m_mode == 1 && m_act) begin
      c = m_cur[87:0];
      if (!m_first) c[1] = 1'b0;
      dn = (m_shown == int'(m_cur[95:88]) + 1);
    end
    return {dn, (mq.size() != 0 || m_mode != 0), (mq.size() < 8), 4'(mq.size()), c};
  endfunction

  // Apply the sequencing rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int sz;
    bit avail, fetch;
    if (rst) begin
      mq.delete();
      m_mode = 0;
      m_act  = 0;
      return;
    end
    sz    = mq.size();
    avail = (sz > 0);
    fetch = 0;
    case (m_mode)
      0: fetch = avail && !pause;
      1: begin
        if (m_shown == int'(m_cur[95:88]) + 1) begin
          m_act = 0;
          if (m_cur[96])            m_mode = 2;
          else if (avail && !pause) fetch  = 1;
          else                      m_mode = 0;
        end else if (pause) begin
          m_act = 0;
        end else begin
          m_act   = 1;
          m_first = 0;
          m_shown++;
        end
      end
      default: if (done) begin
        if (avail) fetch  = 1;
        else       m_mode = 0;
      end
    endcase
    if (fetch) begin
      m_cur   = mq.pop_front();
      m_mode  = 1;
      m_shown = 1;
      m_act   = 1;
      m_first = 1;
    end
    if (valid && sz < 8) mq.push_back(instr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; pause = 1'b0; done = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      rst = 1'b1; valid = 1'b1; pause = 1'b0; done = 1'b0; instr = rand_instr(3, 1);
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL reset_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      checks++;
      if ({count, ready, busy, instr_done} !== 7'b0000_1_0_0 || obs()[87:0] !== '0) begin
        fails++; $display("FAIL reset_state c%0d: got cnt=%0d rdy=%b busy=%b done=%b want 0/1/0/0", c, count, ready, busy, instr_done);
      end
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_single();
    logic [96:0] a;
    int dones = 0;
    do_reset();
    a = rand_instr(0, 0); a[14:7] = 8'h10; a[35:20] = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      valid = (c == 0); instr = a;
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL single_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (instr_done === 1'b1) dones++;
      if (c == 1) begin
        checks++;
        if (row !== 8'h10 || d1 !== 16'h1234 || rd_start !== a[1]) begin
          fails++; $display("FAIL single_fields: got row=%h d1=%h start=%b want 10/1234/%b", row, d1, rd_start, a[1]);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (dones != 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_repeat();
    logic [96:0] a;
    int issues = 0, starts = 0;
    do_reset();
    a = rand_instr(0, 0); a[1] = 1'b1; a[14:7] = 8'hA5; a[95:88] = 8'd3;
    for (int c = 0; c < 7; c++) begin
      valid = (c == 0); instr = a;
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL repeat_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (row === 8'hA5) issues++;
      if (rd_start === 1'b1) starts++;
      checks++;
      if (instr_done !== (c == 4)) begin
        fails++; $display("FAIL repeat_done c%0d: got %b want %b", c, instr_done, (c == 4));
      end
    end
    valid = 1'b0;
    checks++;
    if (issues != 4 || starts != 1) begin
      fails++; $display("FAIL repeat_counts: got issues=%0d starts=%0d want 4/1", issues, starts);
    end
  endtask

  task automatic test_fifo_full();
    logic [96:0] lst[9];
    do_reset();
    pause = 1'b1;
    for (int c = 0; c < 9; c++) begin
      lst[c] = rand_instr(0, 0);
      valid = 1'b1; instr = lst[c];
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL full_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (c >= 7) begin
        checks++;
        if (count !== 4'd8 || ready !== 1'b0) begin
          fails++; $display("FAIL full_level c%0d: got cnt=%0d rdy=%b want 8/0", c, count, ready);
        end
      end
    end
    valid = 1'b0; pause = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL b2b_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      checks++;
      if (c < 8 && (instr_done !== 1'b1 || d1 !== lst[c][35:20])) begin
        fails++; $display("FAIL b2b_issue c%0d: got done=%b d1=%h want 1/%h", c, instr_done, d1, lst[c][35:20]);
      end else if (c >= 8 && (busy !== 1'b0 || instr_done !== 1'b0)) begin
        fails++; $display("FAIL b2b_drain c%0d: got busy=%b done=%b want 0/0", c, busy, instr_done);
      end
    end
  endtask

  task automatic test_wait();
    logic [96:0] w, b;
    do_reset();
    w = rand_instr(0, 0); w[96] = 1'b1;
    b = rand_instr(0, 0);
    for (int c = 0; c < 8; c++) begin
      valid = (c <= 1); instr = (c == 0) ? w : b;
      done  = (c == 2 || c == 6);
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL wait_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      checks++;
      if (c == 1 && instr_done !== 1'b1) begin
        fails++; $display("FAIL wait_retire: got done=%b want 1", instr_done);
      end else if (c >= 2 && c <= 5 && (obs()[87:0] !== '0 || busy !== 1'b1 || instr_done !== 1'b0)) begin
        fails++; $display("FAIL wait_barrier c%0d: got ctrl=%h busy=%b want 0/1", c, obs()[87:0], busy);
      end else if (c == 6 && obs()[87:0] !== b[87:0]) begin
        fails++; $display("FAIL wait_release: got %h want %h", obs()[87:0], b[87:0]);
      end
    end
    valid = 1'b0; done = 1'b0;
  endtask

  task automatic test_pause_mid();
    logic [96:0] a;
    int issues = 0, starts = 0;
    do_reset();
    a = rand_instr(0, 0); a[1] = 1'b1; a[14:7] = 8'h3C; a[95:88] = 8'd3;
    for (int c = 0; c < 9; c++) begin
      valid = (c == 0); instr = a;
      pause = (c == 2 || c == 3);
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL pause_model c%0d: got %h want %h", c, obs(), exp_v());
      end
      if (row === 8'h3C) issues++;
      if (rd_start === 1'b1) starts++;
      if (c == 2 || c == 3 || c == 6) begin
        checks++;
        if ((c != 6 && obs()[87:0] !== '0) || instr_done !== (c == 6)) begin
          fails++; $display("FAIL pause_cycle c%0d: got ctrl=%h done=%b", c, obs()[87:0], instr_done);
        end
      end
    end
    valid = 1'b0; pause = 1'b0;
    checks++;
    if (issues != 4 || starts != 1) begin
      fails++; $display("FAIL pause_counts: got issues=%0d starts=%0d want 4/1", issues, starts);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      valid = 1'b1; instr = rand_instr(0, 0); instr[95:88] = 8'd5;
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL rstmid_model c%0d: got %h want %h", c, obs(), exp_v());
      end
    end
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got cnt=%0d busy=%b want 3/1", count, busy);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; valid = 1'b0;
    checks++;
    if (count !== 4'd0 || ready !== 1'b1 || busy !== 1'b0 || obs()[87:0] !== '0 || instr_done !== 1'b0) begin
      fails++; $display("FAIL rstmid_clear: got cnt=%0d rdy=%b busy=%b ctrl=%h", count, ready, busy, obs()[87:0]);
    end
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++;
      if (obs() !== exp_v() || busy !== 1'b0) begin
        fails++; $display("FAIL rstmid_after c%0d: got %h want %h", c, obs(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      valid = $urandom_range(0, 1) == 1;
      instr = rand_instr(3, 1);
      pause = ($urandom_range(0, 4) == 0);
      done  = ($urandom_range(0, 5) == 0);
      cyc();
      checks++;
      if (obs() !== exp_v()) begin
        fails++; $display("FAIL random_model c%0d: got %h want %h", c, obs(), exp_v());
      end
    end
    rst = 1'b0; valid = 1'b0; pause = 1'b0; done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; pause = 1'b0; done = 1'b0; instr = '0;
    test_reset();
    test_single();
    test_repeat();
    test_fifo_full();
    test_wait();
    test_pause_mid();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Buffered, parametrised successor to the flat instruction decoder. It accepts wide TPU instruction words from the host over a valid/ready handshake and stores them in an internal FIFO.
- It issues each word onto registered control outputs for a programmable repeat count, with an optional wait-for-done barrier. Strobe fields are shaped into proper pulses.
- It sits between the host/instruction source and the unified buffer, systolic array and VPU.

Parameters:
- DATA_W, 16, width of each host write-data field, inv_batch_size_times_two and leak factor
- ROW_W, 8, ub_rd_row_size width
- COL_W, 2, ub_rd_col_size width
- ADDR_W, 2, ub_rd_addr_in width
- PTR_W, 3, ub_ptr_sel width
- PATH_W, 4, vpu_data_pathway width
- REP_W, 8, repeat-count field width
- DEPTH, 8, instruction FIFO entries (power of two, >=2)
- INSTR_W, derived: 5+COL_W+ROW_W+ADDR_W+PTR_W+4*DATA_W+PATH_W+REP_W+1 (97 at defaults)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_in  in  INSTR_W  instruction word
- instr_valid_in  in  1  host presents instr_in
- instr_ready_out  out  1  FIFO not full
- pause_in  in  1  freeze issue
- done_in  in  1  completion event releasing a WAIT barrier
- sys_switch_in, ub_rd_start_in, ub_rd_transpose, ub_wr_host_valid_in_1, ub_wr_host_valid_in_2  out  1 each  decoded strobes/flags
- ub_rd_col_size / ub_rd_row_size / ub_rd_addr_in / ub_ptr_sel  out  COL_W/ROW_W/ADDR_W/PTR_W  read-side fields
- ub_wr_host_data_in_1, ub_wr_host_data_in_2  out  DATA_W each  host write data
- vpu_data_pathway  out  PATH_W  VPU mode
- inv_batch_size_times_two_in, vpu_leak_factor_in  out  DATA_W each  VPU constants
- instr_done_out  out  1  one-cycle pulse when an instruction retires
- busy_out  out  1  FIFO non-empty or FSM not IDLE
- fifo_count_out  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Field layout is packed LSB-first: sys_switch[0], rd_start[1], transpose[2], wr_valid_1[3], wr_valid_2[4], then col, row, addr, ptr, data_1, data_2, pathway, inv_batch, leak, repeat (REP_W), wait (MSB). Default layout bits 0..87 keep the legacy 88-bit positions.
- FIFO push when instr_valid_in & instr_ready_out at the rising edge. instr_ready_out = (count < DEPTH) and is registered-count based, with no bypass from a same-cycle pop.
- All decoded outputs are registered. A NOP is all outputs zero.
- FSM states:
  - IDLE: outputs NOP. If FIFO non-empty and !pause_in, pop, load output registers, load rep_cnt = repeat field, go ISSUE.
  - ISSUE: the instruction is driven. ub_rd_start_in is high only in the first issue cycle; every other field is held on all R+1 cycles (R = repeat). When rep_cnt==0 the instruction retires: instr_done_out pulses that cycle. Then:
    - wait bit=1 → WAIT.
    - Else FIFO non-empty → pop next (back-to-back, no bubble).
    - Else → IDLE.
    - Otherwise rep_cnt decrements.
  - WAIT: outputs NOP. On done_in=1, go to IDLE-equivalent fetch, with the pop in the same edge if FIFO non-empty. done_in outside WAIT is ignored.
- pause_in in ISSUE: outputs forced NOP, rep_cnt frozen, no pop or retire. On resume, the remaining cycles are issued and ub_rd_start_in is NOT re-pulsed. pause_in in IDLE blocks the pop. WAIT ignores pause_in.
- Latency: a push at edge k into an empty, idle sequencer drives outputs after edge k+1.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo DEPTH.
- rst, including mid-instruction: FIFO emptied, state IDLE, all outputs 0, instr_ready_out=1, busy_out=0, fifo_count_out=0.

Test Plan:
- Reset, then push A (row=8'h10, data_1=16'h1234, repeat=0, wait=0) → outputs reflect A in exactly one cycle, two edges after the push. ub_rd_start_in pulses only if bit1 is set. instr_done_out pulses once.
- Push A (repeat=3, rd_start=1) → fields held 4 cycles, ub_rd_start_in high in cycle 1 only, instr_done_out in cycle 4.
- Push 8 instructions with pause_in=1 → instr_ready_out=0 and fifo_count_out=8; a 9th valid is not accepted. Release pause → 8 back-to-back issues with no bubble.
- Instruction with wait=1 followed by B → NOP after retire. B is not issued until done_in pulses, then B appears on the next edge. An earlier done_in has no effect.
- pause_in asserted for 2 cycles mid repeat=3 → NOP for 2 cycles, then the remaining cycles resume. Total issued cycles is 4 and start is not re-pulsed.
- Assert rst during ISSUE with 3 entries queued → all outputs 0 next cycle, fifo_count_out=0, and no further issue.
